// File: rtl/fetch_if.sv
// Fetch <-> ROM/decoder bundle: ROM address/data, decoded instruction out,
// redirect controls back in.
interface fetch_if #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 9
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic [INSTR_W-1:0] instruction;
  logic [PC_W-1:0]    instr_pc;
  logic               instr_valid;
  logic               branch;
  logic               branch_taken;
  logic               jmp_ctrl;
  logic [PC_W-1:0]    jmp_target;
  logic               done_ctrl;

  modport master (
    output imem_addr, instruction, instr_pc, instr_valid,
    input  imem_data, branch, branch_taken,
    input  jmp_ctrl, jmp_target, done_ctrl
  );

  modport slave (
    input  imem_addr, instruction, instr_pc, instr_valid,
    output imem_data, branch, branch_taken,
    output jmp_ctrl, jmp_target, done_ctrl
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch front end: IDLE/RUN/HALT PC sequencer over a 1-cycle ROM.
// FETCH_PERF_EN adds saturating retire/cycle counters.
module fetch_unit #(
  parameter int              PC_W       = 8,
  parameter int              INSTR_W    = 9,
  parameter logic [PC_W-1:0] START_ADDR = '0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  fetch_if.master     bus,
  output logic        halted,
  output logic [15:0] retire_count,
  output logic [15:0] cycle_count
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } state_t;

  state_t          state, state_n;
  logic [PC_W-1:0] pc, pc_n;
  logic [PC_W-1:0] inflight_pc, inflight_pc_n;
  logic            inflight, inflight_n;
  logic            valid;
  logic            do_halt, do_jmp, do_br;
  logic [PC_W-1:0] br_off;

  assign valid = (state == RUN) & inflight;

  assign bus.imem_addr   = pc;
  assign bus.instruction = bus.imem_data;
  assign bus.instr_pc    = inflight_pc;
  assign bus.instr_valid = valid;
  assign halted          = (state == HALT);

  // Mutually exclusive redirect selects encode the priority order
  assign do_halt = valid & bus.done_ctrl;
  assign do_jmp  = valid & ~bus.done_ctrl & bus.jmp_ctrl;
  assign do_br   = valid & ~bus.done_ctrl & ~bus.jmp_ctrl
                 & bus.branch & bus.branch_taken;

  assign br_off = {{(PC_W-5){bus.imem_data[4]}}, bus.imem_data[4:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      pc          <= START_ADDR;
      inflight    <= 1'b0;
      inflight_pc <= START_ADDR;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      inflight    <= inflight_n;
      inflight_pc <= inflight_pc_n;
    end
  end

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    inflight_n    = inflight;
    inflight_pc_n = inflight_pc;
    unique case (state)
      IDLE: begin
        inflight_n = 1'b0;
        if (start) state_n = RUN;
      end
      RUN: begin
        inflight_n    = 1'b1;
        inflight_pc_n = pc;
        pc_n          = pc + 1'b1;
        unique case (1'b1)
          do_halt: begin
            state_n    = HALT;
            inflight_n = 1'b0;
            pc_n       = pc;
          end
          do_jmp: begin
            pc_n       = bus.jmp_target;
            inflight_n = 1'b0;
          end
          do_br: begin
            pc_n       = inflight_pc + br_off;
            inflight_n = 1'b0;
          end
          default: ;
        endcase
      end
      HALT: inflight_n = 1'b0;
      default: begin
        state_n    = IDLE;
        inflight_n = 1'b0;
      end
    endcase
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      retire_count <= 16'h0000;
      cycle_count  <= 16'h0000;
    end else begin
      if (valid && retire_count != 16'hFFFF)
        retire_count <= retire_count + 16'd1;
      if (state == RUN && cycle_count != 16'hFFFF)
        cycle_count <= cycle_count + 16'd1;
    end
  end
`else
  assign retire_count = 16'h0000;
  assign cycle_count  = 16'h0000;
`endif

endmodule
